// File: rtl/kosei_spi_pkg.sv
// kosei_spi_pkg: shared types and constants for the SPI-to-CSR bridge.
//   state_e                bridge FSM states
//   CMD_WRITE / CMD_READ   command byte encodings
//   *_DEFAULT              default values for the bridge parameters
package kosei_spi_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StCmd,
    StAddr,
    StWdata,
    StWrReq,
    StRdReq,
    StRdDummy,
    StRdata,
    StDone
  } state_e;

  localparam logic [7:0]  CMD_WRITE             = 8'h80;
  localparam logic [7:0]  CMD_READ              = 8'h00;
  localparam int unsigned READY_TIMEOUT_DEFAULT = 16;
  localparam logic [31:0] ERR_DATA_DEFAULT      = 32'hFFFF_FFFF;

endpackage

// File: rtl/kosei_spi_csr_bridge_if.sv
// kosei_spi_csr_bridge_if: CSR bus between the SPI bridge and the CSR block.
//   csr_write/csr_read  strobes, held until csr_ready
//   csr_addr/csr_wdata  address and write data, stable while a strobe is high
//   csr_rdata           read data, valid with csr_ready
//   csr_ready           transaction accepted/complete
// Modports: master (bridge side), slave (CSR block side).
interface kosei_spi_csr_bridge_if;
  logic        csr_write;
  logic        csr_read;
  logic [7:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_ready;

  modport master (
    output csr_write, csr_read, csr_addr, csr_wdata,
    input  csr_rdata, csr_ready
  );

  modport slave (
    input  csr_write, csr_read, csr_addr, csr_wdata,
    output csr_rdata, csr_ready
  );
endinterface

// File: rtl/kosei_spi_sync.sv
// kosei_spi_sync: 2-flop synchronizers for the SPI pins plus edge detection.
//   clk, reset      system clock, async active-high reset
//   spi_*_i         raw SPI pins
//   sck_rise_o/sck_fall_o  one-cycle pulses on synchronized sck edges
//   cs_n_o          synchronized chip select level
//   cs_fall_o       one-cycle pulse on synchronized chip select assertion
//   mosi_o          synchronized MOSI, aligned with sck_rise_o
module kosei_spi_sync (
  input  logic clk,
  input  logic reset,
  input  logic spi_sck_i,
  input  logic spi_cs_n_i,
  input  logic spi_mosi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_n_o,
  output logic cs_fall_o,
  output logic mosi_o
);

  // Bit 0/1 are the synchronizer stages, bit 2 holds the previous synced value.
  logic [2:0] sck_q, sck_d;
  logic [2:0] cs_q, cs_d;
  logic [1:0] mosi_q, mosi_d;

  always_comb begin
    sck_d  = {sck_q[1:0], spi_sck_i};
    cs_d   = {cs_q[1:0], spi_cs_n_i};
    mosi_d = {mosi_q[0], spi_mosi_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q  <= 3'b000;
      cs_q   <= 3'b111;  // idle-high so reset release never looks like a CS fall
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= sck_d;
      cs_q   <= cs_d;
      mosi_q <= mosi_d;
    end
  end

  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign sck_fall_o = ~sck_q[1] & sck_q[2];
  assign cs_n_o     = cs_q[1];
  assign cs_fall_o  = ~cs_q[1] & cs_q[2];
  assign mosi_o     = mosi_q[1];

endmodule

// File: rtl/kosei_spi_csr_bridge.sv
// kosei_spi_csr_bridge: SPI mode-0 slave that turns register frames into CSR
// transactions. Frame: cmd byte (80 write / 00 read), addr byte, then either
// 4 write-data bytes or 1 dummy byte followed by 4 read-data bytes on MISO.
//   clk, reset              system clock (>= 8x sck), async active-high reset
//   spi_sck/cs_n/mosi       SPI inputs, oversampled in the clk domain
//   spi_miso, spi_miso_oe   serial read data and its output enable
//   csr                     CSR bus master (kosei_spi_csr_bridge_if)
//   busy                    frame in progress (FSM not idle)
//   err_timeout             sticky CSR timeout flag, cleared on frame start
// Optional: define KOSEI_SPI_AUTOINC_EN to continue a frame with further
// words at csr_addr+4 while CS stays low.
module kosei_spi_csr_bridge
  import kosei_spi_pkg::*;
#(
  parameter int unsigned READY_TIMEOUT = READY_TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_DATA      = ERR_DATA_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          spi_sck,
  input  logic                          spi_cs_n,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  output logic                          spi_miso_oe,
  kosei_spi_csr_bridge_if.master        csr,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int unsigned    TmoW    = $clog2(READY_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(READY_TIMEOUT - 1);

  logic sck_rise, sck_fall, cs_n_s, cs_fall, mosi_s;

  kosei_spi_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .spi_sck_i  (spi_sck),
    .spi_cs_n_i (spi_cs_n),
    .spi_mosi_i (spi_mosi),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .cs_n_o     (cs_n_s),
    .cs_fall_o  (cs_fall),
    .mosi_o     (mosi_s)
  );

  state_e          state_q, state_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [30:0]     sh_in_q, sh_in_d;
  logic [31:0]     sh_out_q, sh_out_d;
  logic            is_read_q, is_read_d;
  logic [7:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
`ifdef KOSEI_SPI_AUTOINC_EN
  logic            more_q, more_d;  // a word has already completed in this frame
`endif

  logic [31:0] rx_word;
  logic [7:0]  rx_byte;
  logic        strobe_busy;
  state_e      exit_st;

  assign rx_word     = {sh_in_q, mosi_s};
  assign rx_byte     = rx_word[7:0];
  assign strobe_busy = wr_q | rd_q;
  // An in-flight strobe must finish before the FSM may return to idle.
  assign exit_st     = strobe_busy ? StDone : StIdle;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_in_d   = sh_in_q;
    sh_out_d  = sh_out_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
`ifdef KOSEI_SPI_AUTOINC_EN
    more_d    = more_q;
`endif

    if (cs_fall) err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          if (strobe_busy) begin
            state_d = StDone;
          end else begin
            state_d   = StCmd;
            bit_cnt_d = 5'd0;
`ifdef KOSEI_SPI_AUTOINC_EN
            more_d    = 1'b0;
`endif
          end
        end
      end
      StCmd: begin
        if (cs_n_s) begin
          state_d = exit_st;
        end else if (sck_rise) begin
          sh_in_d   = rx_word[30:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q[2:0] == 3'd7) begin
            bit_cnt_d = 5'd0;
            if (rx_byte == CMD_WRITE) begin
              is_read_d = 1'b0;
              state_d   = StAddr;
            end else if (rx_byte == CMD_READ) begin
              is_read_d = 1'b1;
              state_d   = StAddr;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      StAddr: begin
        if (cs_n_s) begin
          state_d = exit_st;
        end else if (sck_rise) begin
          sh_in_d   = rx_word[30:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q[2:0] == 3'd7) begin
            bit_cnt_d = 5'd0;
            addr_d    = rx_byte;
            if (is_read_q) begin
              state_d = StRdReq;
              rd_d    = 1'b1;
              tmo_d   = '0;
            end else begin
              state_d = StWdata;
            end
          end
        end
      end
      StWdata: begin
        if (cs_n_s) begin
          state_d = exit_st;
        end else if (sck_rise) begin
          sh_in_d   = rx_word[30:0];
          bit_cnt_d = bit_cnt_q + 5'd1;  // wraps to 0 after the 32nd bit
          if (bit_cnt_q == 5'd31) begin
            wdata_d = rx_word;
            wr_d    = 1'b1;
            tmo_d   = '0;
            state_d = StWrReq;
`ifdef KOSEI_SPI_AUTOINC_EN
            if (more_q) addr_d = addr_q + 8'd4;
            more_d = 1'b1;
`endif
          end
        end
      end
      StWrReq: begin
`ifdef KOSEI_SPI_AUTOINC_EN
        state_d = StWdata;
`else
        state_d = StDone;
`endif
      end
      StRdReq: state_d = StRdDummy;  // read request runs during the dummy byte
      StRdDummy: begin
        if (cs_n_s) begin
          state_d = exit_st;
        end else if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q[2:0] == 3'd7) begin
            bit_cnt_d = 5'd0;
            state_d   = StRdata;
          end
        end
      end
      StRdata: begin
        if (cs_n_s) begin
          state_d = exit_st;
        end else begin
          // Bit 31 is already on MISO when the phase starts; the first fall
          // of the phase must not shift it away before the host samples it.
          if (sck_fall && (bit_cnt_q != 5'd0)) sh_out_d = {sh_out_q[30:0], 1'b0};
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
`ifdef KOSEI_SPI_AUTOINC_EN
              // One-bit gap: reuse the dummy state for a single sck period.
              addr_d    = addr_q + 8'd4;
              rd_d      = 1'b1;
              tmo_d     = '0;
              bit_cnt_d = 5'd7;
              state_d   = StRdDummy;
`else
              state_d = StDone;
`endif
            end
          end
        end
      end
      StDone: begin
        if (cs_n_s && !strobe_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // CSR handshake; runs independently of the FSM so aborted frames still
    // let an issued strobe complete.
    if (strobe_busy) begin
      if (csr.csr_ready) begin
        wr_d = 1'b0;
        rd_d = 1'b0;
        if (rd_q) sh_out_d = csr.csr_rdata;
      end else if (tmo_q >= TmoLast) begin
        wr_d  = 1'b0;
        rd_d  = 1'b0;
        err_d = 1'b1;
        if (rd_q) sh_out_d = ERR_DATA;
      end else if (tmo_q != '1) begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      sh_in_q   <= '0;
      sh_out_q  <= '0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
`ifdef KOSEI_SPI_AUTOINC_EN
      more_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_in_q   <= sh_in_d;
      sh_out_q  <= sh_out_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`ifdef KOSEI_SPI_AUTOINC_EN
      more_q    <= more_d;
`endif
    end
  end

  assign csr.csr_write = wr_q;
  assign csr.csr_read  = rd_q;
  assign csr.csr_addr  = addr_q;
  assign csr.csr_wdata = wdata_q;

  assign spi_miso    = (state_q == StRdata) && sh_out_q[31];
  assign spi_miso_oe = ((state_q == StRdDummy) || (state_q == StRdata)) && !cs_n_s;
  assign busy        = (state_q != StIdle);
  assign err_timeout = err_q;

endmodule
